// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shift_pkg;

   localparam int unsigned SR_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } seq_state_t;

endpackage

// File: rtl/bit_period_timer.sv
// Loadable down-counter that marks the last cycle of each serial bit period.
module bit_period_timer #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   input  logic             en,
   output logic             expire
);

   logic [DIV_W-1:0] r_count;

   // Load wins over counting; wrap after expiry is harmless since the FSM reloads or leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en) begin
         r_count <= r_count - DIV_W'(1);
      end
   end

   assign expire = (r_count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Drives an external left-shift register so its MSB presents each accepted word serially,
// MSB first, one bit per (div+1) clock cycles.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int unsigned DATA_W = SR_WIDTH,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DIV_W-1:0]  div,
   input  logic              abort,
   output logic              sr_load_en,
   output logic              sr_shift_en,
   output logic [DATA_W-1:0] sr_data_in,
   output logic              bit_valid,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   seq_state_t        r_state;
   seq_state_t        w_state_d;
   logic [DATA_W-1:0] r_hold;
   logic [DIV_W-1:0]  r_div;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic              w_accept;
   logic              w_last;
   logic              w_expire;
   logic              w_tmr_load;
   logic              w_tmr_en;

   // Abort in IDLE suppresses the accept, so the word is simply not taken.
   assign w_accept = (r_state == IDLE) && in_valid && !abort;
   assign w_last   = (r_bit_cnt == CNT_W'(DATA_W - 1));

   // Outputs decoded from registered state only.
   assign in_ready    = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign sr_load_en  = (r_state == LOAD);
   assign bit_valid   = (r_state == SHIFT);
   assign done        = (r_state == DONE);
   assign sr_shift_en = (r_state == SHIFT) && w_expire && !w_last;
   assign sr_data_in  = r_hold;

   bit_period_timer #(
      .DIV_W (DIV_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (r_div),
      .en       (w_tmr_en),
      .expire   (w_expire)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state and timer control.
   always_comb begin
      w_state_d  = r_state;
      w_tmr_load = 1'b0;
      w_tmr_en   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_d = LOAD;
            end
         end
         LOAD: begin
            w_tmr_load = 1'b1;
            w_state_d  = abort ? IDLE : SHIFT;
         end
         SHIFT: begin
            w_tmr_en = 1'b1;
            if (abort) begin
               w_state_d = IDLE;
            end else if (w_expire) begin
               if (w_last) begin
                  w_state_d = DONE;
               end else begin
                  w_tmr_load = 1'b1;
               end
            end
         end
         DONE: begin
            w_state_d = IDLE;
         end
         default: begin
            w_state_d = IDLE;
         end
      endcase
   end

   // Word and divider capture at accept; bit counter restarts in LOAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold    <= '0;
         r_div     <= '0;
         r_bit_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_hold <= in_data;
            r_div  <= div;
         end
         if (r_state == LOAD) begin
            r_bit_cnt <= '0;
         end else if (sr_shift_en) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: sequencer driving a behavioural 8-bit left-shift register.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] div;
   logic       abort;
   logic       sr_load_en;
   logic       sr_shift_en;
   logic [7:0] sr_data_in;
   logic       bit_valid;
   logic       busy;
   logic       done;
   logic [7:0] sr_q;

   int checks   = 0;
   int failures = 0;
   int shift_cnt = 0;
   int done_cnt  = 0;
   int both_cnt  = 0;

   always #5 clk = ~clk;

   shift_sequencer #(
      .DATA_W (8),
      .DIV_W  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .div         (div),
      .abort       (abort),
      .sr_load_en  (sr_load_en),
      .sr_shift_en (sr_shift_en),
      .sr_data_in  (sr_data_in),
      .bit_valid   (bit_valid),
      .busy        (busy),
      .done        (done)
   );

   // Downstream shift register sharing the reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else if (sr_load_en) begin
         sr_q <= sr_data_in;
      end else if (sr_shift_en) begin
         sr_q <= {sr_q[6:0], 1'b0};
      end
   end

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (sr_shift_en) shift_cnt++;
      if (done) done_cnt++;
      if (sr_load_en && sr_shift_en) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a word in the current cycle and check every cycle through the idle cycle after done.
   task automatic run_word(input logic [7:0] data, input logic [7:0] d, input logic v_after,
                           input logic [7:0] data_after, input logic [7:0] div_after);
      int n;
      int s0;
      int d0;
      n = int'(d) + 1;
      in_valid = 1'b1;
      in_data  = data;
      div      = d;
      chk("c0_ready", 32'(in_ready), 32'd1);
      s0 = shift_cnt;
      d0 = done_cnt;
      tick();
      in_valid = v_after;
      in_data  = data_after;
      div      = div_after;
      chk("load_en", 32'(sr_load_en), 32'd1);
      chk("load_busy", 32'(busy), 32'd1);
      chk("load_ready", 32'(in_ready), 32'd0);
      tick();
      for (int i = 0; i < 8 * n; i++) begin
         int k;
         k = i / n;
         chk("bit_valid", 32'(bit_valid), 32'd1);
         chk("serial", 32'(sr_q[7]), 32'(data[7-k]));
         chk("shift_en", 32'(sr_shift_en), 32'((i % n == n - 1) && (k < 7)));
         chk("data_in", 32'(sr_data_in), 32'(data));
         tick();
      end
      chk("done", 32'(done), 32'd1);
      chk("done_ready", 32'(in_ready), 32'd0);
      chk("done_bit_valid", 32'(bit_valid), 32'd0);
      chk("shift_pulses", 32'(shift_cnt - s0), 32'd7);
      tick();
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      int s0;
      int d0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      div      = '0;
      abort    = 1'b0;
      tick();
      tick();
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_outs", 32'({sr_load_en, sr_shift_en, bit_valid, done}), 32'd0);
      chk("rst_data_in", 32'(sr_data_in), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 32'(in_ready), 32'd1);

      // Single word at full rate.
      run_word(8'hA5, 8'd0, 1'b0, 8'h00, 8'd0);
      // Slow rate, 4 cycles per bit.
      run_word(8'h81, 8'd3, 1'b0, 8'h00, 8'd0);
      // Back-to-back with in_valid held; data/div change mid-word must not matter.
      run_word(8'hFF, 8'd0, 1'b1, 8'h00, 8'd5);
      run_word(8'h00, 8'd0, 1'b0, 8'h00, 8'd0);

      // Abort during bit 3 of 0xC3 at div=1.
      in_valid = 1'b1;
      in_data  = 8'hC3;
      div      = 8'd1;
      tick();
      in_valid = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) tick();
      chk("abort_bit3", 32'(sr_q[7]), 32'd0);
      chk("abort_bv", 32'(bit_valid), 32'd1);
      s0 = shift_cnt;
      d0 = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
      chk("abort_bv_off", 32'(bit_valid), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      chk("abort_no_shift", 32'(shift_cnt - s0), 32'd0);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // Abort in IDLE blocks the accept.
      in_valid = 1'b1;
      in_data  = 8'h77;
      abort    = 1'b1;
      tick();
      in_valid = 1'b0;
      abort    = 1'b0;
      chk("idle_abort_load", 32'(sr_load_en), 32'd0);
      chk("idle_abort_busy", 32'(busy), 32'd0);
      run_word(8'h5A, 8'd0, 1'b0, 8'h00, 8'd0);

      // Reset mid-word.
      in_valid = 1'b1;
      in_data  = 8'h3C;
      div      = 8'd2;
      tick();
      in_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) tick();
      chk("pre_rst_bv", 32'(bit_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_outs", 32'({sr_load_en, sr_shift_en, bit_valid, done}), 32'd0);
      chk("mid_rst_data_in", 32'(sr_data_in), 32'd0);
      chk("mid_rst_sr", 32'(sr_q), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      run_word(8'h96, 8'd1, 1'b0, 8'h00, 8'd0);

      // Maximum divider: 256 cycles per bit.
      run_word(8'h6D, 8'hFF, 1'b0, 8'h00, 8'd0);

      chk("load_shift_exclusive", 32'(both_cnt), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
